// File: rtl/verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec_if.sv
// Avalon-MM master bundle used by the OCI debug-memory executor.
interface verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;
  logic              m_waitrequest;

  modport master (
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec.sv
// Debug-memory command executor: turns JTAG ocimem strobes into Avalon-MM reads/writes.
// Optional wait-request abort enabled by defining VERIN_AVALON_OCIMEM_TIMEOUT_EN.
module verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec_if.master m_bus,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mon_q, mon_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              any_strobe;

`ifdef VERIN_AVALON_OCIMEM_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    err_d   = err_q;
`ifdef VERIN_AVALON_OCIMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_W+7:8];
          if (jdo[35]) err_d = 1'b0;
          if (jdo[34]) begin
            state_d = StRd;
            ready_d = 1'b0;
          end else begin
            // Address-only load completes immediately.
            ready_d = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = StWr;
          ready_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = StRd;
          ready_d = 1'b0;
        end
      end
      StRd, StWr: begin
        if (any_strobe) err_d = 1'b1;
        if (!m_bus.m_waitrequest) begin
          if (state_q == StRd) mon_d = m_bus.m_readdata;
          addr_d  = addr_q + AddrOne;
          state_d = StIdle;
          ready_d = 1'b1;
`ifdef VERIN_AVALON_OCIMEM_TIMEOUT_EN
          cnt_d   = 8'd0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
          ready_d = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    read_d  = (state_d == StRd);
    write_d = (state_d == StWr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

`ifdef VERIN_AVALON_OCIMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign m_bus.m_address   = addr_q;
  assign m_bus.m_read      = read_q;
  assign m_bus.m_write     = write_q;
  assign m_bus.m_writedata = wdata_q;
  assign MonDReg           = mon_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = err_q;

endmodule

// File: tb/tb_verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec.sv
// Directed self-checking bench for the OCI debug-memory executor.
module tb_verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        act_a, noact_a, act_b;
  logic [31:0] mon_dreg;
  logic        mon_ready, mon_error;

  int n_cmp = 0;
  int n_err = 0;

  verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec_if #(.ADDR_W(10)) bus ();

  verin_avalon_nios2_gen2_0_cpu_debug_ocimem_exec #(
    .ADDR_W        (10),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (act_a),
    .take_no_action_ocimem_a(noact_a),
    .take_action_ocimem_b   (act_b),
    .m_bus                  (bus),
    .MonDReg                (mon_dreg),
    .monitor_ready          (mon_ready),
    .monitor_error          (mon_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [9:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j       = '0;
    j[17:8] = addr;
    j[34]   = rd;
    j[35]   = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j;
    j      = '0;
    j[34:3] = data;
    return j;
  endfunction

  int wr_cycles;
  int rd_cycles;
  int data_bad;

  initial begin
    reset = 1'b1;
    jdo = '0;
    act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
    bus.m_readdata = '0;
    bus.m_waitrequest = 1'b0;
    tick();
    tick();
    check("rst_read",  {31'd0, bus.m_read}, 32'd0);
    check("rst_write", {31'd0, bus.m_write}, 32'd0);
    check("rst_addr",  {22'd0, bus.m_address}, 32'd0);
    check("rst_wdata", bus.m_writedata, 32'd0);
    check("rst_mon",   mon_dreg, 32'd0);
    check("rst_ready", {31'd0, mon_ready}, 32'd0);
    check("rst_error", {31'd0, mon_error}, 32'd0);
    reset = 1'b0;
    tick();

    // Address load + read, zero wait states.
    bus.m_readdata = 32'hDEADBEEF;
    jdo = mk_a(10'h010, 1'b1, 1'b0);
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
    check("rd_m_read",  {31'd0, bus.m_read}, 32'd1);
    check("rd_m_write", {31'd0, bus.m_write}, 32'd0);
    check("rd_addr",    {22'd0, bus.m_address}, 32'h010);
    check("rd_ready_lo", {31'd0, mon_ready}, 32'd0);
    tick();
    check("rd_done_read", {31'd0, bus.m_read}, 32'd0);
    check("rd_mon",       mon_dreg, 32'hDEADBEEF);
    check("rd_ready_hi",  {31'd0, mon_ready}, 32'd1);
    check("rd_addr_inc",  {22'd0, bus.m_address}, 32'h011);

    // Write at 0x3FF with three wait-request cycles, address wraps.
    jdo = mk_a(10'h3FF, 1'b0, 1'b0);
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
    check("ld_addr",  {22'd0, bus.m_address}, 32'h3FF);
    check("ld_ready", {31'd0, mon_ready}, 32'd1);
    bus.m_waitrequest = 1'b1;
    jdo = mk_b(32'h12345678);
    act_b = 1'b1;
    tick();
    act_b = 1'b0;
    wr_cycles = 0;
    data_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.m_write) begin
        wr_cycles++;
        if (bus.m_writedata !== 32'h12345678) data_bad++;
        if (bus.m_read) data_bad++;
      end
      if (wr_cycles == 4) bus.m_waitrequest = 1'b0;
      tick();
    end
    check("wr_cycles",   wr_cycles, 32'd4);
    check("wr_data_bad", data_bad, 32'd0);
    check("wr_wrap",     {22'd0, bus.m_address}, 32'h000);
    check("wr_ready",    {31'd0, mon_ready}, 32'd1);
    check("wr_wdata",    bus.m_writedata, 32'h12345678);

    // Strobe during an outstanding read is dropped and flags an error.
    bus.m_waitrequest = 1'b1;
    noact_a = 1'b1;
    tick();
    check("na_read", {31'd0, bus.m_read}, 32'd1);
    tick();
    noact_a = 1'b0;
    check("drop_err",   {31'd0, mon_error}, 32'd1);
    check("drop_read",  {31'd0, bus.m_read}, 32'd1);
    check("drop_addr",  {22'd0, bus.m_address}, 32'h000);
    bus.m_readdata = 32'hCAFEF00D;
    bus.m_waitrequest = 1'b0;
    tick();
    check("drop_mon",  mon_dreg, 32'hCAFEF00D);
    check("drop_inc",  {22'd0, bus.m_address}, 32'h001);
    check("err_stick", {31'd0, mon_error}, 32'd1);
    jdo = mk_a(10'h005, 1'b0, 1'b1);
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
    check("err_clear", {31'd0, mon_error}, 32'd0);
    check("clr_addr",  {22'd0, bus.m_address}, 32'h005);

    // Wait-request stuck high.
    bus.m_waitrequest = 1'b1;
    noact_a = 1'b1;
    tick();
    noact_a = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.m_read) rd_cycles++;
      tick();
    end
`ifdef VERIN_AVALON_OCIMEM_TIMEOUT_EN
    check("to_cycles", rd_cycles, 32'd255);
    check("to_read",   {31'd0, bus.m_read}, 32'd0);
    check("to_err",    {31'd0, mon_error}, 32'd1);
    check("to_addr",   {22'd0, bus.m_address}, 32'h005);
    check("to_ready",  {31'd0, mon_ready}, 32'd1);
    check("to_mon",    mon_dreg, 32'hCAFEF00D);
    bus.m_waitrequest = 1'b0;
`else
    check("stuck_cycles", rd_cycles, 32'd1000);
    check("stuck_read",   {31'd0, bus.m_read}, 32'd1);
    check("stuck_err",    {31'd0, mon_error}, 32'd0);
    bus.m_readdata = 32'h00C0FFEE;
    bus.m_waitrequest = 1'b0;
    tick();
    check("stuck_done", {31'd0, bus.m_read}, 32'd0);
    check("stuck_mon",  mon_dreg, 32'h00C0FFEE);
    check("stuck_inc",  {22'd0, bus.m_address}, 32'h006);
`endif

    // Reset in the middle of a stalled write.
    bus.m_waitrequest = 1'b1;
    jdo = mk_b(32'hA5A5A5A5);
    act_b = 1'b1;
    tick();
    act_b = 1'b0;
    check("pre_rst_write", {31'd0, bus.m_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_write", {31'd0, bus.m_write}, 32'd0);
    check("mid_rst_outs",
          {bus.m_writedata | mon_dreg | {22'd0, bus.m_address}},
          32'd0);
    check("mid_rst_flags", {29'd0, bus.m_read, mon_ready, mon_error}, 32'd0);
    tick();
    reset = 1'b0;
    bus.m_waitrequest = 1'b0;
    bus.m_readdata = 32'h0BADF00D;
    jdo = mk_a(10'h020, 1'b1, 1'b0);
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
    check("post_rst_read", {31'd0, bus.m_read}, 32'd1);
    check("post_rst_addr", {22'd0, bus.m_address}, 32'h020);
    tick();
    check("post_rst_mon",  mon_dreg, 32'h0BADF00D);
    check("post_rst_inc",  {22'd0, bus.m_address}, 32'h021);
    check("post_rst_rdy",  {31'd0, mon_ready}, 32'd1);

    // Simultaneous ocimem_a and ocimem_b: address load wins.
    jdo = mk_a(10'h0AB, 1'b0, 1'b0);
    jdo[33:18] = 16'hFFFF;
    act_a = 1'b1;
    act_b = 1'b1;
    tick();
    act_a = 1'b0;
    act_b = 1'b0;
    check("prio_write", {31'd0, bus.m_write}, 32'd0);
    check("prio_read",  {31'd0, bus.m_read}, 32'd0);
    check("prio_addr",  {22'd0, bus.m_address}, 32'h0AB);
    check("prio_err",   {31'd0, mon_error}, 32'd0);
    check("prio_wdata", bus.m_writedata, 32'd0);
    tick();
    check("prio_write2", {31'd0, bus.m_write}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
